// File: rtl/switch_debouncer.sv
// Switch-bank conditioner: per-bit synchroniser followed by an independent
// stability counter per bit. Produces a clean level bus plus one-cycle
// rise/fall strobes and a combined change strobe, all registered.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Plain flop chain per bit; nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-bit filter: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync[i];
          rise_d[i]   = sync[i];
          fall_d[i]   = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      any_q    <= any_d;
    end
  end

  assign sw_stable  = stable_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus a randomized phase, all
// compared every cycle against a window-based reference model.
module tb_switch_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         any_change;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(
    .WIDTH          (W),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  // Reference model: raw values delayed SS edges give the synchronised value;
  // a bit is accepted when the last DC synchronised samples all differ from it.
  logic [W-1:0] m_rawq [SS];
  logic [W-1:0] m_win  [DC];
  logic [W-1:0] m_stable, m_rise, m_fall;
  logic         m_any;

  task automatic model_step();
    logic [W-1:0] s;
    bit all_diff;
    if (reset) begin
      for (int k = 0; k < int'(SS); k++) m_rawq[k] = '0;
      for (int k = 0; k < int'(DC); k++) m_win[k] = '0;
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_any    = 1'b0;
    end else begin
      s = m_rawq[SS-1];
      for (int k = int'(DC) - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = s;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < int'(W); i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < int'(DC); k++) begin
          if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (m_stable[i]) m_fall[i] = 1'b1;
          else             m_rise[i] = 1'b1;
          m_stable[i] = ~m_stable[i];
        end
      end
      m_any = |(m_rise | m_fall);
      for (int k = int'(SS) - 1; k > 0; k--) m_rawq[k] = m_rawq[k-1];
      m_rawq[0] = sw_raw;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update model on the edge, sample DUT 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("stable", 32'(sw_stable), 32'(m_stable));
    check("rise",   32'(sw_rise),   32'(m_rise));
    check("fall",   32'(sw_fall),   32'(m_fall));
    check("any",    32'(any_change), 32'(m_any));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int n;
    int cnt_a;
    int cnt_b;

    // 1. Reset held 3 cycles with all switches high.
    reset  = 1'b1;
    sw_raw = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_stable", 32'(sw_stable), 32'h0);
      check("rst_pulse", 32'(sw_rise | sw_fall), 32'h0);
    end
    reset = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sw_stable == 4'hF) begin
        n = k;
        break;
      end
    end
    check("rst_latency", 32'(n), 32'd6);
    check("rst_rise", 32'(sw_rise), 32'hF);
    tick();
    check("rst_rise_width", 32'(sw_rise), 32'h0);

    // 2. Clean step on bit 0.
    sw_raw = 4'hE;
    ticks(8);
    sw_raw = 4'hF;
    n = 0;
    cnt_a = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sw_fall != 0) cnt_a++;
      if (sw_stable[0]) begin
        n = k;
        break;
      end
    end
    check("step_latency", 32'(n), 32'd6);
    check("step_rise", 32'(sw_rise), 32'h1);
    check("step_any", 32'(any_change), 32'h1);
    check("step_nofall", 32'(cnt_a), 32'd0);
    tick();
    check("step_rise_width", 32'(sw_rise), 32'h0);

    // 3. Glitch on bit 1 lasting 3 cycles is rejected.
    sw_raw = 4'hD;
    ticks(8);
    sw_raw[1] = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (sw_rise[1] | sw_fall[1]) cnt_a++;
    end
    sw_raw[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sw_rise[1] | sw_fall[1]) cnt_a++;
    end
    check("glitch_stable", 32'(sw_stable[1]), 32'h0);
    check("glitch_pulses", 32'(cnt_a), 32'd0);

    // 4. Bounce on bit 2 settling high.
    sw_raw[2] = 1'b0;
    ticks(8);
    cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      sw_raw[2] = ~k[0];
      tick();
      if (sw_rise[2]) cnt_a++;
    end
    sw_raw[2] = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sw_rise[2]) cnt_a++;
      if (sw_stable[2] && n == 0) n = k;
    end
    check("bounce_latency", 32'(n), 32'd6);
    check("bounce_rises", 32'(cnt_a), 32'd1);

    // 5. Bits 0 and 3 fall together.
    sw_raw = 4'b0100;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (sw_fall == 4'b1001) cnt_a++;
      if (any_change) cnt_b++;
    end
    check("simul_fall", 32'(cnt_a), 32'd1);
    check("simul_any", 32'(cnt_b), 32'd1);

    // 6. Reset while bit 1 is part-way through its count.
    sw_raw[1] = 1'b1;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sw_stable[1]) begin
        n = k;
        break;
      end
    end
    check("midrst_latency", 32'(n), 32'd6);

    // Randomized phase: sparse toggles, occasional reset.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) sw_raw[$urandom_range(W - 1)] ^= 1'b1;
      if ($urandom_range(4) == 0) sw_raw = 4'($urandom);
      reset = ($urandom_range(149) == 0);
      tick();
    end
    reset = 1'b0;
    ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
